// File: rtl/pc.sv
// Program counter register: holds the fetch address and loads the externally
// selected next-PC value on every rising clock edge.
module pc #(
  parameter int unsigned       WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] PC_next,
  output logic [WIDTH-1:0] PC_out
);

  logic [WIDTH-1:0] r_pc;

  // Reset wins over a coincident edge; PC_next is stored verbatim, no masking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_VALUE;
    end else begin
      r_pc <= PC_next;
    end
  end

  assign PC_out = r_pc;

endmodule

// File: tb/tb_pc.sv
// Self-checking bench for pc: directed reset/priority cases plus randomized
// load/reset traffic checked against an expected-value model every cycle.
module tb_pc;

  localparam int unsigned WIDTH = 32;
  localparam logic [31:0] RV    = 32'h0000_0000;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] PC_next;
  logic [WIDTH-1:0] PC_out;

  int unsigned n_total;
  int unsigned n_pass;

  logic [31:0] exp_pc;
  bit          exp_valid;

  pc #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RV)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .PC_next (PC_next),
    .PC_out  (PC_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) begin
      n_pass++;
    end else begin
      $display("FAIL %s: PC_out=%h expected=%h at t=%0t", name, act, req, $time);
    end
  endtask

  // Model: the register shows the last value applied before an edge, or the
  // reset value whenever reset has been asserted since that edge.
  task automatic cycle(input bit rst_v, input logic [31:0] nxt);
    rst     = rst_v;
    PC_next = nxt;
    if (rst_v) exp_pc = RV;
    @(posedge clk);
    #1;
    exp_pc = rst_v ? RV : nxt;
  endtask

  always @(negedge clk) begin
    if (exp_valid) check("model", PC_out, exp_pc);
  end

  initial begin
    n_total   = 0;
    n_pass    = 0;
    exp_valid = 1'b0;
    exp_pc    = RV;
    rst       = 1'b0;
    PC_next   = '0;

    // Reset hold, then release and first load
    cycle(1'b1, 32'hDEAD_BEEF);
    exp_valid = 1'b1;
    check("reset_hold", PC_out, 32'h0);
    cycle(1'b1, 32'hDEAD_BEEF);
    check("reset_hold2", PC_out, 32'h0);
    cycle(1'b0, 32'hAAAA_BBBB);
    check("release_load", PC_out, 32'hAAAA_BBBB);

    // Back-to-back and unmasked loads
    cycle(1'b0, 32'h1234_5678);
    check("b2b_0", PC_out, 32'h1234_5678);
    cycle(1'b0, 32'hCAFE_BABE);
    check("b2b_1", PC_out, 32'hCAFE_BABE);
    cycle(1'b0, 32'h0000_0003);
    check("no_mask_low", PC_out, 32'h0000_0003);
    cycle(1'b0, 32'hFFFF_FFFF);
    check("all_ones", PC_out, 32'hFFFF_FFFF);
    cycle(1'b0, 32'h0000_0000);
    check("all_zeros", PC_out, 32'h0000_0000);

    // Asynchronous reset with clk low and nonzero value stored
    cycle(1'b0, 32'h8765_4321);
    @(negedge clk);
    #2;
    rst    = 1'b1;
    exp_pc = RV;
    #1;
    check("async_reset", PC_out, 32'h0);
    cycle(1'b1, 32'hDEAD_BEEF);
    check("async_hold", PC_out, 32'h0);
    cycle(1'b0, 32'h0000_1000);
    check("async_release", PC_out, 32'h0000_1000);

    // Reset coincident with a rising edge
    PC_next = 32'h5555_AAAA;
    @(posedge clk);
    rst    = 1'b1;
    exp_pc = RV;
    #1;
    check("reset_priority", PC_out, 32'h0);
    cycle(1'b0, 32'h0000_2000);
    check("priority_release", PC_out, 32'h0000_2000);

    // Mid-run half-period reset pulse
    cycle(1'b0, 32'hCAFE_BABE);
    check("pre_pulse", PC_out, 32'hCAFE_BABE);
    rst    = 1'b1;
    exp_pc = RV;
    #1;
    check("pulse_immediate", PC_out, 32'h0);
    #4;
    rst = 1'b0;
    #1;
    check("pulse_after_release", PC_out, 32'h0);
    cycle(1'b0, 32'h1357_2468);
    check("pulse_resume", PC_out, 32'h1357_2468);

    // Randomized loads with occasional resets
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 15) == 0), $urandom);
    end
    cycle(1'b0, 32'h0BAD_F00D);
    check("final_load", PC_out, 32'h0BAD_F00D);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
